// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out deserializer with a one-frame holding register and valid/ready output.
// Frames assemble in a shift register while the previous frame waits in the holding register.
module sipo_deserializer #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             clr_overrun
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_base;
  logic [WIDTH-1:0] shift_ins;
  logic [WIDTH-1:0] shift_next;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_base;
  logic [CW-1:0]    count_next;
  logic [WIDTH-1:0] hold_reg;
  logic             valid_reg;
  logic             valid_next;
  logic             overrun_reg;
  logic             overrun_next;
  logic             frame_done;
  logic             load;
  logic             drop;

  // frame_sync throws away the partial frame before this cycle's bit is taken in
  assign shift_base = frame_sync ? '0 : shift_reg;
  assign count_base = frame_sync ? '0 : count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (LSB_FIRST) begin : g_lsb
        if (gi == WIDTH - 1) begin : g_in
          assign shift_ins[gi] = serial_in;
        end else begin : g_mv
          assign shift_ins[gi] = shift_base[gi+1];
        end
      end else begin : g_msb
        if (gi == 0) begin : g_in
          assign shift_ins[gi] = serial_in;
        end else begin : g_mv
          assign shift_ins[gi] = shift_base[gi-1];
        end
      end
    end
  endgenerate

  assign frame_done = bit_valid && (count_base == CW'(WIDTH - 1));
  // A finished frame can enter the holding register if it is empty or is being drained now
  assign load       = frame_done && (!valid_reg || out_ready);
  assign drop       = frame_done && !load;

  always_comb begin
    shift_next   = shift_base;
    count_next   = count_base;
    valid_next   = valid_reg && !out_ready;
    overrun_next = overrun_reg && !clr_overrun;
    if (bit_valid) begin
      shift_next = shift_ins;
      count_next = frame_done ? '0 : count_base + CW'(1);
    end
    if (load) begin
      valid_next = 1'b1;
    end
    if (drop) begin
      overrun_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg   <= '0;
      count_reg   <= '0;
      hold_reg    <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      shift_reg   <= shift_next;
      count_reg   <= count_next;
      valid_reg   <= valid_next;
      overrun_reg <= overrun_next;
      if (load) begin
        hold_reg <= shift_ins;
      end
    end
  end

  assign parallel_out = hold_reg;
  assign out_valid    = valid_reg;
  assign busy         = (count_reg != '0);
  assign overrun      = overrun_reg;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: a 4-bit LSB-first instance and an 8-bit MSB-first instance.
// Expected frames are queued when their last bit is driven and popped when the DUT presents them.
module tb_sipo_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       serial_in, bit_valid, frame_sync, out_ready, clr_overrun;
  logic [3:0] parallel_out;
  logic       out_valid, busy, overrun;
  logic       s8, bv8, fs8, rdy8, clr8;
  logic [7:0] po8;
  logic       valid8, busy8, ovr8;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [3:0] exp_q[$];
  logic [7:0] exp8_q[$];
  logic [3:0] exp4;
  logic [7:0] exp8;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(4), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .serial_in(serial_in), .bit_valid(bit_valid),
    .frame_sync(frame_sync), .parallel_out(parallel_out), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  sipo_deserializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut8 (
    .clk(clk), .rst(rst), .serial_in(s8), .bit_valid(bv8),
    .frame_sync(fs8), .parallel_out(po8), .out_valid(valid8),
    .out_ready(rdy8), .busy(busy8), .overrun(ovr8), .clr_overrun(clr8)
  );

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic drive_bit(input logic b, input logic sync);
    serial_in = b; bit_valid = 1'b1; frame_sync = sync;
    @(posedge clk); #1;
    bit_valid = 1'b0; frame_sync = 1'b0;
  endtask

  task automatic drive_bit8(input logic b);
    s8 = b; bv8 = 1'b1;
    @(posedge clk); #1;
    bv8 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    rst = 1'b0; serial_in = 0; bit_valid = 0; frame_sync = 0; out_ready = 0; clr_overrun = 0;
    s8 = 0; bv8 = 0; fs8 = 0; rdy8 = 0; clr8 = 0;
    repeat (2) @(posedge clk); #1;
    n_cmp++; if ({parallel_out, out_valid, busy, overrun} !== 7'b0) begin
      n_err++; $display("FAIL reset4: got %b expected 0000000", {parallel_out, out_valid, busy, overrun});
    end
    n_cmp++; if ({po8, valid8, busy8, ovr8} !== 11'b0) begin
      n_err++; $display("FAIL reset8: got %b expected 0", {po8, valid8, busy8, ovr8});
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_frame;
    logic [3:0] v = 4'b1101;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back(v);
      drive_bit(v[i], 1'b0);
      if (i == 2) begin
        n_cmp++; if (busy !== 1'b1 || out_valid !== 1'b0) begin
          n_err++; $display("FAIL single_mid: got busy=%b valid=%b expected busy=1 valid=0", busy, out_valid);
        end
      end
    end
    exp4 = exp_q.pop_front();
    n_cmp++; if (out_valid !== 1'b1) begin
      n_err++; $display("FAIL single_valid: got %b expected 1", out_valid);
    end
    n_cmp++; if (parallel_out !== exp4) begin
      n_err++; $display("FAIL single_data: got %b expected %b", parallel_out, exp4);
    end
    n_cmp++; if (busy !== 1'b0 || overrun !== 1'b0) begin
      n_err++; $display("FAIL single_flags: got busy=%b ovr=%b expected 0 0", busy, overrun);
    end
  endtask

  task automatic test_overrun;
    logic [3:0] held = 4'b1101;
    logic b;
    for (int i = 0; i < 8; i++) begin
      b = 1'($urandom_range(0, 1));
      drive_bit(b, 1'b0);
      n_cmp++; if (parallel_out !== held) begin
        n_err++; $display("FAIL ovr_hold%0d: got %b expected %b", i, parallel_out, held);
      end
      if (i == 2) begin
        n_cmp++; if (overrun !== 1'b0) begin
          n_err++; $display("FAIL ovr_early: got %b expected 0", overrun);
        end
      end
    end
    n_cmp++; if (overrun !== 1'b1 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL ovr_set: got ovr=%b valid=%b expected 1 1", overrun, out_valid);
    end
    clr_overrun = 1'b1; idle(1); clr_overrun = 1'b0;
    n_cmp++; if (overrun !== 1'b0) begin
      n_err++; $display("FAIL ovr_clear: got %b expected 0", overrun);
    end
    for (int i = 0; i < 3; i++) drive_bit(1'b0, 1'b0);
    clr_overrun = 1'b1;
    drive_bit(1'b1, 1'b0);
    clr_overrun = 1'b0;
    n_cmp++; if (overrun !== 1'b1 || parallel_out !== held) begin
      n_err++; $display("FAIL ovr_clr_vs_drop: got ovr=%b data=%b expected 1 %b", overrun, parallel_out, held);
    end
    clr_overrun = 1'b1; idle(1); clr_overrun = 1'b0;
    out_ready = 1'b1; idle(1);
    n_cmp++; if (out_valid !== 1'b0 || overrun !== 1'b0) begin
      n_err++; $display("FAIL ovr_drain: got valid=%b ovr=%b expected 0 0", out_valid, overrun);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] f [2];
    f[0] = 4'b0011; f[1] = 4'b1010;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        if (i == 3) exp_q.push_back(f[k]);
        drive_bit(f[k][i], 1'b0);
        if (k == 1 && i == 0) begin
          n_cmp++; if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL b2b_accept: got %b expected 0", out_valid);
          end
        end
      end
      exp4 = exp_q.pop_front();
      n_cmp++; if (out_valid !== 1'b1 || parallel_out !== exp4) begin
        n_err++; $display("FAIL b2b_frame%0d: got valid=%b data=%b expected 1 %b", k, out_valid, parallel_out, exp4);
      end
    end
    n_cmp++; if (overrun !== 1'b0) begin
      n_err++; $display("FAIL b2b_overrun: got %b expected 0", overrun);
    end
    idle(1);
    // consumer takes the old frame on the exact cycle the next one completes
    out_ready = 1'b0;
    f[0] = 4'b0101; f[1] = 4'b1110;
    exp_q.push_back(f[0]);
    for (int i = 0; i < 4; i++) drive_bit(f[0][i], 1'b0);
    exp4 = exp_q.pop_front();
    for (int i = 0; i < 3; i++) begin
      drive_bit(f[1][i], 1'b0);
      n_cmp++; if (out_valid !== 1'b1 || parallel_out !== exp4) begin
        n_err++; $display("FAIL cont_hold%0d: got valid=%b data=%b expected 1 %b", i, out_valid, parallel_out, exp4);
      end
    end
    out_ready = 1'b1;
    exp_q.push_back(f[1]);
    drive_bit(f[1][3], 1'b0);
    exp4 = exp_q.pop_front();
    n_cmp++; if (out_valid !== 1'b1 || parallel_out !== exp4 || overrun !== 1'b0) begin
      n_err++; $display("FAIL cont_swap: got valid=%b data=%b ovr=%b expected 1 %b 0", out_valid, parallel_out, overrun, exp4);
    end
    idle(1);
    n_cmp++; if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL cont_drain: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_frame_sync;
    out_ready = 1'b1;
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b1);
    n_cmp++; if (busy !== 1'b1) begin
      n_err++; $display("FAIL sync_busy: got %b expected 1", busy);
    end
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL sync_early: got %b expected 0", out_valid);
    end
    exp_q.push_back(4'b1001);
    drive_bit(1'b1, 1'b0);
    exp4 = exp_q.pop_front();
    n_cmp++; if (out_valid !== 1'b1 || parallel_out !== exp4) begin
      n_err++; $display("FAIL sync_frame: got valid=%b data=%b expected 1 %b", out_valid, parallel_out, exp4);
    end
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    frame_sync = 1'b1; idle(1); frame_sync = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin
      n_err++; $display("FAIL sync_only: got busy=%b expected 0", busy);
    end
    exp_q.push_back(4'b0111);
    for (int i = 0; i < 4; i++) drive_bit(i < 3, 1'b0);
    exp4 = exp_q.pop_front();
    n_cmp++; if (out_valid !== 1'b1 || parallel_out !== exp4) begin
      n_err++; $display("FAIL sync_after: got valid=%b data=%b expected 1 %b", out_valid, parallel_out, exp4);
    end
  endtask

  task automatic test_async_reset;
    logic [3:0] v = 4'b0110;
    idle(1);
    out_ready = 1'b0;
    exp_q.push_back(4'b0101);
    for (int i = 0; i < 4; i++) drive_bit(i[0] == 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) drive_bit(1'b1, 1'b0);
    n_cmp++; if ({out_valid, busy, overrun} !== 3'b111) begin
      n_err++; $display("FAIL rst_pre: got %b expected 111", {out_valid, busy, overrun});
    end
    #3 rst = 1'b0;
    #1;
    n_cmp++; if ({parallel_out, out_valid, busy, overrun} !== 7'b0) begin
      n_err++; $display("FAIL rst_async: got %b expected 0000000", {parallel_out, out_valid, busy, overrun});
    end
    exp_q.delete();
    #2 rst = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back(v);
      drive_bit(v[i], 1'b0);
    end
    exp4 = exp_q.pop_front();
    n_cmp++; if (out_valid !== 1'b1 || parallel_out !== exp4) begin
      n_err++; $display("FAIL rst_after: got valid=%b data=%b expected 1 %b", out_valid, parallel_out, exp4);
    end
  endtask

  task automatic test_msb_first_w8;
    logic [7:0] pats [3];
    pats[0] = 8'b10000001; pats[1] = 8'b11000000; pats[2] = 8'b10000001;
    rdy8 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      // first received bit lands in the MSB
      for (int i = 7; i >= 0; i--) begin
        if (i == 0) exp8_q.push_back(pats[k]);
        drive_bit8(pats[k][i]);
        if (k == 2 && i != 0) idle(1 + (i % 2));
        if (k == 2 && i == 4) begin
          n_cmp++; if (busy8 !== 1'b1 || valid8 !== 1'b0) begin
            n_err++; $display("FAIL w8_gap: got busy=%b valid=%b expected 1 0", busy8, valid8);
          end
        end
      end
      exp8 = exp8_q.pop_front();
      n_cmp++; if (valid8 !== 1'b1 || po8 !== exp8) begin
        n_err++; $display("FAIL w8_frame%0d: got valid=%b data=%b expected 1 %b", k, valid8, po8, exp8);
      end
    end
    n_cmp++; if (ovr8 !== 1'b0 || busy8 !== 1'b0) begin
      n_err++; $display("FAIL w8_flags: got ovr=%b busy=%b expected 0 0", ovr8, busy8);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_overrun();
    test_back_to_back();
    test_frame_sync();
    test_async_reset();
    test_msb_first_w8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
